// File: rtl/rpsc_fault_input_qualifier.sv
// rtl/rpsc_fault_input_qualifier.sv - sync, debounce and glitch-count the raw PS/amp fault lines
// Qualified levels feed the Card-9 *_IN fault inputs; the first qualified fault is held for the panel.
module rpsc_fault_input_qualifier #(
  parameter int N_CH         = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int ASSERT_CYC   = 16,
  parameter int DEASSERT_CYC = 64,
  parameter int CNT_W        = 8,
  parameter int CHATTER_LIM  = 4
) (
  input  logic                    clk,
  input  logic                    reset_from_card6,
  input  logic [N_CH-1:0]         fault_raw_in,
  input  logic                    fault_ack_in,
  output logic [N_CH-1:0]         fault_qual_out,
  output logic [N_CH-1:0]         fault_rise_out,
  output logic                    any_fault_out,
  output logic                    first_valid_out,
  output logic [$clog2(N_CH)-1:0] first_id_out,
  output logic [N_CH-1:0]         chatter_out
);

  localparam int ID_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] ASSERT_LAST   = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] DEASSERT_LAST = CNT_W'(DEASSERT_CYC - 1);
  localparam logic [3:0]       CHATTER_TH    = 4'(CHATTER_LIM);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    Q_ON   = 2'b01,
    ACTIVE = 2'b10,
    Q_OFF  = 2'b11
  } qual_state_t;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    qual_state_t            state;
    qual_state_t            state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   rise_next;
    logic                   glitch_ev;
    logic                   rise_q;
    logic [3:0]             glitch;

    always_ff @(posedge clk or negedge reset_from_card6) begin
      if (!reset_from_card6) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], fault_raw_in[ch]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_from_card6) begin
      if (!reset_from_card6) begin
        state  <= IDLE;
        cnt    <= '0;
        rise_q <= 1'b0;
      end else begin
        state  <= state_next;
        cnt    <= cnt_next;
        rise_q <= rise_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rise_next  = 1'b0;
      glitch_ev  = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_next = Q_ON;
            cnt_next   = CNT_W'(1);
          end
        end
        Q_ON: begin
          if (!s) begin
            state_next = IDLE;
            cnt_next   = '0;
            glitch_ev  = 1'b1;
          end else if (cnt == ASSERT_LAST) begin
            state_next = ACTIVE;
            cnt_next   = '0;
            rise_next  = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (!s) begin
            state_next = Q_OFF;
            cnt_next   = CNT_W'(1);
          end
        end
        Q_OFF: begin
          // A single high sample re-arms the full release window without a new rise.
          if (s) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else if (cnt == DEASSERT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_from_card6) begin
      if (!reset_from_card6) begin
        glitch <= '0;
      end else if (fault_ack_in) begin
        glitch <= '0;
      end else if (glitch_ev && (glitch != 4'hF)) begin
        glitch <= glitch + 4'd1;
      end
    end

    assign fault_qual_out[ch] = (state == ACTIVE) || (state == Q_OFF);
    assign fault_rise_out[ch] = rise_q;
    assign chatter_out[ch]    = (glitch >= CHATTER_TH);
  end

  assign any_fault_out = |fault_qual_out;

  logic [ID_W-1:0] rise_low;

  always_comb begin
    rise_low = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fault_rise_out[i]) rise_low = ID_W'(i);
    end
  end

  // A rise coincident with ack wins, so a fresh fault is never lost to the clear.
  always_ff @(posedge clk or negedge reset_from_card6) begin
    if (!reset_from_card6) begin
      first_valid_out <= 1'b0;
      first_id_out    <= '0;
    end else if ((|fault_rise_out) && (!first_valid_out || fault_ack_in)) begin
      first_valid_out <= 1'b1;
      first_id_out    <= rise_low;
    end else if (fault_ack_in) begin
      first_valid_out <= 1'b0;
      first_id_out    <= '0;
    end
  end

endmodule

// File: tb/tb_rpsc_fault_input_qualifier.sv
// tb/tb_rpsc_fault_input_qualifier.sv - directed bench for rpsc_fault_input_qualifier
module tb_rpsc_fault_input_qualifier;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw;
  logic       ack;
  logic [7:0] qual;
  logic [7:0] rise;
  logic       any_f;
  logic       valid;
  logic [2:0] id;
  logic [7:0] chatter;

  int checks;
  int failures;

  rpsc_fault_input_qualifier dut (
    .clk              (clk),
    .reset_from_card6 (rst_n),
    .fault_raw_in     (raw),
    .fault_ack_in     (ack),
    .fault_qual_out   (qual),
    .fault_rise_out   (rise),
    .any_fault_out    (any_f),
    .first_valid_out  (valid),
    .first_id_out     (id),
    .chatter_out      (chatter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 15 high samples then low: one short of qualifying, so exactly one glitch.
  task automatic glitch_pulse(input int ch, output logic seen_qual);
    seen_qual = 1'b0;
    raw[ch] = 1'b1;
    repeat (15) begin
      tick();
      seen_qual |= qual[ch];
    end
    raw[ch] = 1'b0;
    repeat (6) begin
      tick();
      seen_qual |= qual[ch];
    end
  endtask

  logic seen;
  logic q_min;
  logic r_max;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    raw      = 8'hFF;
    ack      = 1'b0;

    // T1: reset holds everything at zero, then 18-edge assert latency
    repeat (3) tick();
    check("rst_qual", qual, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_any", any_f, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_id", id, 3'd0);
    check("rst_chatter", chatter, 8'h00);
    rst_n = 1'b1;
    repeat (17) tick();
    check("t1_qual_e17", qual, 8'h00);
    tick();
    check("t1_qual_e18", qual, 8'hFF);
    check("t1_rise_e18", rise, 8'hFF);
    check("t1_any", any_f, 1'b1);
    tick();
    check("t1_rise_e19", rise, 8'h00);
    check("t1_valid", valid, 1'b1);
    check("t1_id_lowest", id, 3'd0);

    // release latency: 66 edges after raw drops
    raw = 8'h00;
    repeat (65) tick();
    check("t1_rel_e65", qual, 8'hFF);
    tick();
    check("t1_rel_e66", qual, 8'h00);
    check("t1_any_off", any_f, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_ack_valid", valid, 1'b0);

    // T2: four sub-threshold pulses on ch2 build up chatter
    for (int i = 0; i < 4; i++) begin
      glitch_pulse(2, seen);
      check($sformatf("t2_noqual_%0d", i), seen, 1'b0);
      check($sformatf("t2_chatter_%0d", i), chatter, (i >= 3) ? 8'h04 : 8'h00);
    end

    // T3: ch5 qualifies, 63 low samples then one high keeps it asserted
    raw[5] = 1'b1;
    repeat (20) tick();
    check("t3_qual_on", qual, 8'h20);
    check("t3_first_id", id, 3'd5);
    q_min = 1'b1;
    r_max = 1'b0;
    raw[5] = 1'b0;
    repeat (63) begin
      tick();
      q_min &= qual[5];
      r_max |= rise[5];
    end
    raw[5] = 1'b1;
    tick();
    q_min &= qual[5];
    r_max |= rise[5];
    raw[5] = 1'b0;
    repeat (65) begin
      tick();
      q_min &= qual[5];
      r_max |= rise[5];
    end
    check("t3_hold", q_min, 1'b1);
    check("t3_no_rise", r_max, 1'b0);
    tick();
    check("t3_released", qual[5], 1'b0);
    check("t3_valid_pre_ack", valid, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t3_ack_valid", valid, 1'b0);
    check("t3_ack_id", id, 3'd0);
    check("t3_ack_chatter", chatter, 8'h00);

    // T4: ch6 and ch3 rise together, later ch0 rise must not displace the record
    raw = 8'h48;
    repeat (17) tick();
    check("t4_rise_e17", rise, 8'h00);
    tick();
    check("t4_rise_e18", rise, 8'h48);
    check("t4_qual", qual, 8'h48);
    tick();
    check("t4_valid", valid, 1'b1);
    check("t4_id", id, 3'd3);
    raw[0] = 1'b1;
    repeat (18) tick();
    check("t4_rise_ch0", rise, 8'h01);
    tick();
    check("t4_id_kept", id, 3'd3);
    check("t4_qual_all", qual, 8'h49);

    // T5: ack coincident with ch7 rise, after ch4 has chattered
    for (int i = 0; i < 4; i++) begin
      glitch_pulse(4, seen);
    end
    check("t5_chatter_pre", chatter, 8'h10);
    raw[7] = 1'b1;
    repeat (18) tick();
    check("t5_rise", rise, 8'h80);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_valid", valid, 1'b1);
    check("t5_id", id, 3'd7);
    check("t5_chatter_clr", chatter, 8'h00);

    // T6: reset while ch1 is in its release window
    raw = 8'h02;
    repeat (20) tick();
    check("t6_qual1_on", qual[1], 1'b1);
    raw = 8'h00;
    repeat (10) tick();
    check("t6_qual1_qoff", qual[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_qual", qual, 8'h00);
    check("t6_async_valid", valid, 1'b0);
    raw = 8'h02;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (17) tick();
    check("t6_restart_e17", qual, 8'h00);
    tick();
    check("t6_restart_e18", qual, 8'h02);
    check("t6_restart_rise", rise, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
